// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals for uart_tx_arbiter.
// slave: the arbiter's view. master: the producers' and transmitter's view (testbench).
// req_data packs requester i's byte at [8i+7:8i].
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 tx_active;
  logic                 tx_data_sent;
  logic                 busy;
  logic                 done;
  logic [ID_W-1:0]      done_id;

  modport slave (
    input  req_valid, req_data, tx_active, tx_data_sent,
    output req_ready, tx_en, tx_data, busy, done, done_id
  );

  modport master (
    output req_valid, req_data, tx_active, tx_data_sent,
    input  req_ready, tx_en, tx_data, busy, done, done_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters, one byte per grant.
// Latency: grant registered one edge after req_valid is seen in IDLE; done one edge after tx_data_sent rises.
// Backpressure: req_ready pulses only in IDLE; requesters hold req_valid/req_data until they see it.
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            sent_q;
  logic            sent_rise;
  logic [ID_W-1:0] win_q;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic            grant;
  logic            issue_ack;
  logic            frame_done;

  // Only a 0->1 transition of the end-of-frame flag counts; a level left over from a prior frame does not.
  assign sent_rise = bus.tx_data_sent & ~sent_q;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest asserted requester index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && bus.req_valid[k]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0]    ptr_q;
  logic [NUM_REQ-1:0] rot;
  logic [ID_W:0]      sum;

  // Round-robin: rotate the request vector so bit k is requester (ptr+k) mod NUM_REQ; first set bit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    rot       = NUM_REQ'({bus.req_valid, bus.req_valid} >> ptr_q);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && rot[k]) begin
        grant_vld = 1'b1;
        sum       = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
          sum = sum - (ID_W+1)'(NUM_REQ);
        end
        grant_idx = sum[ID_W-1:0];
      end
    end
  end

  // Pointer moves to the slot after the requester whose frame just completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (frame_done) begin
      if (win_q == ID_W'(NUM_REQ - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= win_q + 1'b1;
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and one-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    issue_ack  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The transmitter samples tx_en only on baud ticks, so hold it until it reports active.
        if (bus.tx_active) begin
          issue_ack = 1'b1;
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (sent_rise) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: grant pulse, byte latch, enable, completion report; sent_q tracks the flag every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_ready <= '0;
      bus.tx_en     <= 1'b0;
      bus.tx_data   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.done_id   <= '0;
      win_q         <= '0;
      sent_q        <= 1'b0;
    end else begin
      sent_q        <= bus.tx_data_sent;
      bus.busy      <= (state_d != IDLE);
      bus.req_ready <= '0;
      bus.done      <= 1'b0;
      if (grant) begin
        bus.req_ready <= NUM_REQ'(1) << grant_idx;
        bus.tx_data   <= bus.req_data[8*grant_idx +: 8];
        bus.tx_en     <= 1'b1;
        win_q         <= grant_idx;
      end else if (issue_ack) begin
        bus.tx_en     <= 1'b0;
      end
      if (frame_done) begin
        bus.done      <= 1'b1;
        bus.done_id   <= win_q;
      end
    end
  end

endmodule
